// File: rtl/data_inf_arb_pkg.sv
// data_inf_arb_pkg: shared types and helpers for the data_inf stream arbiters
package data_inf_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic int rr_idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_inf_rr_pick.sv
// data_inf_rr_pick: rotating priority encoder, first set req bit at or after ptr
module data_inf_rr_pick
    import data_inf_arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IDW = rr_idw(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    int j;

    // scan from the farthest rotated position down so the one nearest ptr wins
    always_comb begin
        any = |req;
        idx = '0;
        j   = 0;
        for (int k = NUM - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= NUM) ? j - NUM : j;
            if (req[j]) idx = IDW'(j);
        end
    end

endmodule

// File: rtl/data_inf_rr_arbiter.sv
// data_inf_rr_arbiter: round-robin merge of NUM valid/ready streams into one registered stream
module data_inf_rr_arbiter
    import data_inf_arb_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = rr_idw(NUM)
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM*DSIZE-1:0] s_data,
    input  logic [NUM-1:0]       s_valid,
    output logic [NUM-1:0]       s_ready,
    output logic [DSIZE-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IDW-1:0]       m_id
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state, state_next;
    logic [IDW-1:0]  ptr, gnt, idx;
    logic [CW-1:0]   cnt;
    logic            any, gvalid, open, accept, last, rel;

    data_inf_rr_pick #(.NUM(NUM), .IDW(IDW)) u_pick (
        .req(s_valid),
        .ptr(ptr),
        .any(any),
        .idx(idx)
    );

    // output register can take a beat when empty or draining this cycle
    assign gvalid = s_valid[gnt];
    assign open   = !m_valid || m_ready;
    assign accept = (state == GRANT) && gvalid && open;
    assign last   = cnt == CW'(MAX_BURST - 1);
    assign rel    = (state == GRANT) && (!gvalid || (accept && last));

    // state register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state: grant on any request, drop back to IDLE on burst end or valid loss
    always_comb begin
        state_next = (state == IDLE) ? (any ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    end

    // only the granted stream sees ready, and only while the output can take a beat
    always_comb begin
        s_ready = '0;
        if (state == GRANT) s_ready[gnt] = open;
    end

    // grant, burst counter and round-robin pointer
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= '0;
            cnt <= '0;
            ptr <= '0;
        end else begin
            if (state == IDLE && any) begin
                gnt <= idx;
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + CW'(1);
            end
            if (rel) ptr <= (gnt == IDW'(NUM - 1)) ? '0 : gnt + IDW'(1);
        end
    end

    // single registered output stage; held while stalled
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= s_data[int'(gnt)*DSIZE +: DSIZE];
            m_id    <= gnt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_inf_rr_arbiter.sv
// tb_data_inf_rr_arbiter: directed scoreboard bench for the round-robin stream arbiter
module tb_data_inf_rr_arbiter;

    localparam int NUM = 4;
    localparam int DSIZE = 8;
    localparam int MB = 4;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]   s_valid;
    logic [NUM-1:0]   s_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [1:0]       m_id;

    int          rem [NUM];
    logic [7:0]  nxt [NUM];
    logic [NUM-1:0] hs;
    logic [15:0] exp_q [$];
    int          beat_t [$];
    int          cyc;
    int          errors;
    int          checks;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [1:0]  prev_id;

    always #5 clock = ~clock;

    data_inf_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .MAX_BURST(MB)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_id(m_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            s_valid[i] = rem[i] > 0;
            s_data[i*DSIZE +: DSIZE] = nxt[i];
        end
    endtask

    task automatic tick();
        logic [15:0] e;
        drive();
        @(negedge clock);
        cyc++;
        check("s_ready_onehot0", 32'($onehot0(s_ready)), 32'd1);
        if (rst_n) begin
            if (prev_stall) check("stall_hold", 32'({m_valid, m_id, m_data}), 32'({1'b1, prev_id, prev_data}));
            if (m_valid && m_ready) begin
                check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_id_data", 32'({8'(m_id), m_data}), 32'(e));
                end
                beat_t.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_id = m_id;
            prev_data = m_data;
        end else begin
            prev_stall = 1'b0;
        end
        hs = s_valid & s_ready;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (hs[i]) begin
                rem[i]--;
                nxt[i]++;
            end
        end
    endtask

    task automatic drain(input int budget, input bit toggle);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) begin
            if (toggle) m_ready = ~m_ready;
            tick();
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        prev_stall = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            rem[i] = 1;
            nxt[i] = 8'hA0 + 8'(i);
        end
        drive();

        // reset held with every stream requesting
        repeat (3) begin
            tick();
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NUM; i++) push(i, 8'hA0 + 8'(i));
        tick();
        check("first_grant", 32'(s_ready), 32'b0001);
        check("first_m_valid_low", 32'(m_valid), 32'd0);
        tick();
        check("first_m_valid_rise", 32'({m_valid, m_id}), 32'({1'b1, 2'd0}));
        drain(40, 1'b0);

        // round robin, all four streams continuously valid
        for (int i = 0; i < NUM; i++) begin
            rem[i] = 8;
            nxt[i] = 8'h40 + 8'(16 * i);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM; i++)
                for (int k = 0; k < MB; k++)
                    push(i, 8'h40 + 8'(16 * i + 4 * r + k));
        beat_t.delete();
        drain(100, 1'b0);
        check("rr_period", 32'(beat_t[16] - beat_t[0]), 32'd20);

        // single stream with burst gaps
        rem[2] = 10;
        nxt[2] = 8'h10;
        for (int k = 0; k < 10; k++) push(2, 8'h10 + 8'(k));
        beat_t.delete();
        drain(60, 1'b0);
        for (int k = 1; k < 10; k++)
            check("ss_gap", 32'(beat_t[k] - beat_t[k-1]), (k == 4 || k == 8) ? 32'd2 : 32'd1);

        // backpressure with m_ready toggling
        rem[1] = 16;
        nxt[1] = 8'h60;
        for (int k = 0; k < 16; k++) push(1, 8'h60 + 8'(k));
        drain(120, 1'b1);

        // early release of stream 3, ptr wraps to 0 before stream 1
        rem[3] = 2; nxt[3] = 8'hC0;
        rem[0] = 3; nxt[0] = 8'hD0;
        rem[1] = 1; nxt[1] = 8'hE0;
        push(3, 8'hC0); push(3, 8'hC1);
        push(0, 8'hD0); push(0, 8'hD1); push(0, 8'hD2);
        push(1, 8'hE0);
        beat_t.delete();
        drain(60, 1'b0);
        check("early_gap", 32'(beat_t[2] - beat_t[1]), 32'd3);

        // asynchronous reset while a beat is stalled in the output register
        rem[1] = 4;
        nxt[1] = 8'h80;
        m_ready = 1'b0;
        for (int n = 0; n < 10 && !m_valid; n++) tick();
        check("mv_before_reset", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_m_valid", 32'(m_valid), 32'd0);
        check("async_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < NUM; i++) rem[i] = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        rem[1] = 2; nxt[1] = 8'h90;
        rem[3] = 2; nxt[3] = 8'hB0;
        push(1, 8'h90); push(1, 8'h91);
        push(3, 8'hB0); push(3, 8'hB1);
        drain(40, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
